// File: rtl/unsat_clause_tournament_picker.sv
// Picks one clause index by a registered pairwise tournament, one tree level per clock.
// Unsatisfied clauses beat satisfied ones; latched random bits break ties.
module unsat_clause_tournament_picker #(
   parameter int unsigned NUM_CLAUSES                       = 8,
   parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
   parameter int unsigned RANDOM_WIDTH                      = NUM_CLAUSES / 2
) (
   input  logic                                         in_clk,
   input  logic                                         in_reset,
   input  logic                                         in_start,
   input  logic [NUM_CLAUSES-1:0]                       in_clauses_satisfied,
   input  logic [RANDOM_WIDTH-1:0]                      in_random,
   output logic                                         out_busy,
   output logic                                         out_valid,
   output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
   output logic                                         out_all_satisfied,
   output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0]   out_unsat_count
);

   localparam int unsigned IdxW   = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
   localparam int unsigned CntW   = IdxW + 1;
   localparam int unsigned Levels = $clog2(NUM_CLAUSES);
   localparam int unsigned LevelW = $clog2(Levels + 1);
   localparam int unsigned Half   = NUM_CLAUSES / 2;
   localparam logic [LevelW-1:0] LastLevel = LevelW'(Levels - 1);

   typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

   state_e                  state_q, state_d;
   logic [LevelW-1:0]       level_q, level_d;
   logic [IdxW-1:0]         node_idx_q [NUM_CLAUSES];
   logic [IdxW-1:0]         node_idx_d [NUM_CLAUSES];
   logic                    node_sat_q [NUM_CLAUSES];
   logic                    node_sat_d [NUM_CLAUSES];
   logic [RANDOM_WIDTH-1:0] rand_q, rand_d;
   logic [CntW-1:0]         count_q, count_d;
   logic [IdxW-1:0]         res_idx_q, res_idx_d;
   logic                    res_all_q, res_all_d;
   logic [CntW-1:0]         res_cnt_q, res_cnt_d;
   logic [CntW-1:0]         unsat_pop;

   always_comb begin
      unsat_pop = '0;
      for (int i = 0; i < NUM_CLAUSES; i++) begin
         unsat_pop = unsat_pop + CntW'(~in_clauses_satisfied[i]);
      end
   end

   always_comb begin
      int unsigned active_pairs;
      logic        sat_a, sat_b, pick_b;
      state_d    = state_q;
      level_d    = level_q;
      node_idx_d = node_idx_q;
      node_sat_d = node_sat_q;
      rand_d     = rand_q;
      count_d    = count_q;
      res_idx_d  = res_idx_q;
      res_all_d  = res_all_q;
      res_cnt_d  = res_cnt_q;
      active_pairs = (NUM_CLAUSES >> level_q) >> 1;
      sat_a  = 1'b0;
      sat_b  = 1'b0;
      pick_b = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_start) begin
               for (int i = 0; i < NUM_CLAUSES; i++) begin
                  node_idx_d[i] = IdxW'(i);
                  node_sat_d[i] = in_clauses_satisfied[i];
               end
               rand_d  = in_random;
               level_d = '0;
               count_d = unsat_pop;
               state_d = StReduce;
            end
         end
         StReduce: begin
            for (int p = 0; p < Half; p++) begin
               if (p < active_pairs) begin
                  sat_a = node_sat_q[2*p];
                  sat_b = node_sat_q[2*p+1];
                  // Differing status: take whichever is unsatisfied; else the random bit decides.
                  pick_b = (sat_a != sat_b) ? ~sat_b : rand_q[p];
                  node_idx_d[p] = pick_b ? node_idx_q[2*p+1] : node_idx_q[2*p];
                  node_sat_d[p] = sat_a & sat_b;
               end
            end
            level_d = level_q + 1'b1;
            if (level_q == LastLevel) begin
               state_d   = StDone;
               res_idx_d = node_idx_d[0];
               res_all_d = node_sat_d[0];
               res_cnt_d = count_q;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q   <= StIdle;
         level_q   <= '0;
         rand_q    <= '0;
         count_q   <= '0;
         res_idx_q <= '0;
         res_all_q <= 1'b0;
         res_cnt_q <= '0;
         for (int i = 0; i < NUM_CLAUSES; i++) begin
            node_idx_q[i] <= '0;
            node_sat_q[i] <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         rand_q     <= rand_d;
         count_q    <= count_d;
         res_idx_q  <= res_idx_d;
         res_all_q  <= res_all_d;
         res_cnt_q  <= res_cnt_d;
         node_idx_q <= node_idx_d;
         node_sat_q <= node_sat_d;
      end
   end

   assign out_busy          = (state_q == StReduce);
   assign out_valid         = (state_q == StDone);
   assign out_clause_index  = res_idx_q;
   assign out_all_satisfied = res_all_q;
   assign out_unsat_count   = res_cnt_q;

endmodule

// File: tb/tb_unsat_clause_tournament_picker.sv
// Bench for unsat_clause_tournament_picker: fixed vectors, corner sequences, random vs model.
module tb_unsat_clause_tournament_picker;

   localparam int N      = 8;
   localparam int IW     = 3;
   localparam int RW     = 4;
   localparam int LEVELS = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  sat = '0;
   logic [RW-1:0] rnd = '0;
   logic          busy, valid, all_sat;
   logic [IW-1:0] idx;
   logic [IW:0]   cnt;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [N-1:0]  sat;
      logic [RW-1:0] rnd;
      int            idx;
      int            all;
      int            cnt;
   } vec_t;

   vec_t tbl [5];

   always #5 clk = ~clk;

   unsat_clause_tournament_picker #(
      .NUM_CLAUSES                      (N),
      .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(IW),
      .RANDOM_WIDTH                     (RW)
   ) dut (
      .in_clk              (clk),
      .in_reset            (reset),
      .in_start            (start),
      .in_clauses_satisfied(sat),
      .in_random           (rnd),
      .out_busy            (busy),
      .out_valid           (valid),
      .out_clause_index    (idx),
      .out_all_satisfied   (all_sat),
      .out_unsat_count     (cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Tournament computed level by level on plain integer lists.
   function automatic void model(input logic [N-1:0] s, input logic [RW-1:0] r,
                                 output int m_idx, output int m_all, output int m_cnt);
      int ix [N];
      int st [N];
      int n, wi, ws;
      for (int i = 0; i < N; i++) begin
         ix[i] = i;
         st[i] = s[i] ? 1 : 0;
      end
      n = N;
      while (n > 1) begin
         for (int p = 0; p < n / 2; p++) begin
            if (st[2*p] == 0 && st[2*p+1] == 1) wi = ix[2*p];
            else if (st[2*p] == 1 && st[2*p+1] == 0) wi = ix[2*p+1];
            else wi = r[p] ? ix[2*p+1] : ix[2*p];
            ws = st[2*p] & st[2*p+1];
            ix[p] = wi;
            st[p] = ws;
         end
         n = n / 2;
      end
      m_idx = ix[0];
      m_all = st[0];
      m_cnt = N - $countones(s);
   endfunction

   // Drive a start at a negedge; returns at the negedge of the first busy cycle.
   task automatic start_req(input logic [N-1:0] s, input logic [RW-1:0] r);
      @(negedge clk);
      sat   = s;
      rnd   = r;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_result(input string name, input int e_idx, input int e_all,
                                input int e_cnt);
      check({name, " busy1"}, int'(busy), 1);
      check({name, " valid1"}, int'(valid), 0);
      for (int k = 2; k <= LEVELS; k++) begin
         @(negedge clk);
         check({name, " busyN"}, int'(busy), 1);
         check({name, " validN"}, int'(valid), 0);
      end
      @(negedge clk);
      check({name, " valid"}, int'(valid), 1);
      check({name, " busy_done"}, int'(busy), 0);
      check({name, " idx"}, int'(idx), e_idx);
      check({name, " all"}, int'(all_sat), e_all);
      check({name, " cnt"}, int'(cnt), e_cnt);
      @(negedge clk);
      check({name, " pulse"}, int'(valid), 0);
      check({name, " idx_hold"}, int'(idx), e_idx);
   endtask

   initial begin
      int m_idx, m_all, m_cnt;
      logic [N-1:0] rs;
      logic [RW-1:0] rr;

      tbl[0] = '{sat: 8'b1111_1011, rnd: 4'b0000, idx: 2, all: 0, cnt: 1};
      tbl[1] = '{sat: 8'hFF,        rnd: 4'b0000, idx: 0, all: 1, cnt: 0};
      tbl[2] = '{sat: 8'hFF,        rnd: 4'b1111, idx: 7, all: 1, cnt: 0};
      tbl[3] = '{sat: 8'h00,        rnd: 4'b0101, idx: 5, all: 0, cnt: 8};
      tbl[4] = '{sat: 8'b0111_1110, rnd: 4'b0001, idx: 7, all: 0, cnt: 2};

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst busy", int'(busy), 0);
      check("rst valid", int'(valid), 0);
      check("rst idx", int'(idx), 0);
      check("rst all", int'(all_sat), 0);
      check("rst cnt", int'(cnt), 0);

      for (int v = 0; v < 5; v++) begin
         start_req(tbl[v].sat, tbl[v].rnd);
         expect_result($sformatf("tbl%0d", v), tbl[v].idx, tbl[v].all, tbl[v].cnt);
      end

      // Re-pulsed start mid-reduction must be dropped.
      start_req(8'b0111_1110, 4'b0001);
      @(negedge clk);
      check("repulse busy", int'(busy), 1);
      sat   = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("repulse busy3", int'(busy), 1);
      @(negedge clk);
      check("repulse valid", int'(valid), 1);
      check("repulse idx", int'(idx), 7);
      check("repulse cnt", int'(cnt), 2);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("repulse no2nd", int'(valid), 0);
         check("repulse idle", int'(busy), 0);
      end

      // Reset abandons an in-flight reduction.
      start_req(8'h00, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", int'(busy), 0);
      check("abort valid", int'(valid), 0);
      check("abort idx", int'(idx), 0);
      check("abort cnt", int'(cnt), 0);
      start_req(8'b1110_1111, 4'b0000);
      expect_result("after_abort", 4, 0, 1);

      // Start coinciding with reset is ignored.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      sat   = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check("rst_start busy", int'(busy), 0);
      @(negedge clk);
      check("rst_start busy2", int'(busy), 0);
      check("rst_start valid", int'(valid), 0);

      for (int t = 0; t < 40; t++) begin
         rs = N'($urandom);
         rr = RW'($urandom);
         if (t % 10 == 3) rs = '1;
         if (t % 10 == 7) rs = '0;
         model(rs, rr, m_idx, m_all, m_cnt);
         start_req(rs, rr);
         expect_result($sformatf("rnd%0d", t), m_idx, m_all, m_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/unsat_clause_tournament_picker.md
Name: unsat_clause_tournament_picker

Overview:
- Sequential, parametrised successor to the two-input clause checker.
- Latches a vector of per-clause satisfied flags and reduces it with a registered pairwise tournament, one level per clock, to one clause index.
- Prefers an unsatisfied clause; random bits break ties. Also reports whether all clauses were satisfied and how many were unsatisfied.
- Sits in Stochastic_Search between the clause evaluators and the variable-flip selector.

Parameters:
- NUM_CLAUSES, 8, number of clauses; power of two, ≥2.
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 3, index width; must equal log2(NUM_CLAUSES).
- RANDOM_WIDTH, NUM_CLAUSES/2, width of the tie-break random word.

Ports:
- in_clk  input  1  clock; single clock domain, all state updates on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_start  input  1  start request; accepted only in IDLE.
- in_clauses_satisfied  input  NUM_CLAUSES  bit i = 1 when clause i is satisfied.
- in_random  input  RANDOM_WIDTH  tie-break bits; sampled with in_start.
- out_busy  output  1  high while a reduction is in progress.
- out_valid  output  1  one-cycle pulse when the result is ready.
- out_clause_index  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX  selected clause.
- out_all_satisfied  output  1  1 when every clause is satisfied.
- out_unsat_count  output  MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX+1  number of unsatisfied clauses.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all outputs 0; internal level counter and node registers 0.
- Reset has priority over everything, including an in-flight reduction, which is abandoned with no out_valid.
- FSM states: IDLE, REDUCE, DONE.
- IDLE:
  - On in_start=1, latch in_clauses_satisfied into NUM_CLAUSES leaf nodes (index i, sat flag bit i).
  - Latch in_random; level = 0; compute and register unsat_count = popcount of ~in_clauses_satisfied.
  - Go to REDUCE; out_busy = 1 from the next cycle.
- REDUCE:
  - Each cycle, combine node pairs (2p, 2p+1) into node p for p in 0..(active_nodes/2 − 1).
  - Then halve active_nodes and increment level.
  - Stay in REDUCE until level reaches LEVELS = log2(NUM_CLAUSES), then go to DONE.
- Pair rule, with a = node 2p, b = node 2p+1, s = latched random bit p (same bit p at every level):
  - a unsat, b sat → a.
  - a sat, b unsat → b.
  - Both same status → a if s=0, b if s=1.
  - Result sat flag = a.sat AND b.sat.
- DONE (one cycle):
  - out_valid = 1; out_busy = 0.
  - out_clause_index = node 0 index; out_all_satisfied = node 0 sat; out_unsat_count = latched count.
  - Next state IDLE.
- Data outputs hold their value until the next DONE or reset. out_valid is a strict single-cycle pulse.
- Latency: in_start accepted at cycle T → out_valid at cycle T + LEVELS + 1 (N=8: T+4). Throughput is one request per LEVELS+2 cycles.
- in_start while busy or in DONE is ignored and not queued; inputs are sampled only at acceptance.
- in_start in the same cycle as in_reset is ignored.
- Count width: all unsatisfied yields NUM_CLAUSES, which requires the extra bit (N=8 → 4'd8).
- Level counter and node arrays are sized by the parameters; no hard-coded 8. NUM_CLAUSES=2 gives LEVELS=1.

Test Plan:
- N=8, sat=8'b1111_1011, random=4'b0000, start at T → out_valid at T+4, index 2, all_satisfied 0, unsat_count 1; out_busy high T+1..T+3.
- sat=8'hFF, random=4'b0000 → index 0, all_satisfied 1, count 0.
- sat=8'hFF, random=4'b1111 → index 7, all_satisfied 1, count 0.
- sat=8'h00, random=4'b0101:
  - Level 0 winners 1, 2, 5, 6.
  - Level 1 winners 2, 5.
  - Level 2 winner 5.
  - Result: index 5, all_satisfied 0, count 8.
- sat=8'b0111_1110 (clauses 0 and 7 unsat), random=4'b0001 → index 7, count 2.
  - Re-pulse in_start at T+2 with sat=8'h00 → ignored; same result at T+4; no second out_valid.
- Start, then assert in_reset at T+2 for one cycle → no out_valid; all outputs 0 from T+3; new start at T+4 with sat=8'b1110_1111 → index 4 at T+8.
